csr_bank_irq: RTL and testbench
===============================

Name: csr_bank_irq

Overview:
- Parametrised CSR bank for peripheral blocks (UART, timers, GPIO) on the memory-style cs/wen/addr/strb bus.
- Provides NUM_CFG read/write config registers with per-register reset values and a live hardware status register.
- Adds a sticky write-1-to-clear event register, an interrupt enable register with a registered interrupt output, and a registered read path with a valid flag.
- Returns an error pulse on unmapped or misaligned accesses.

Parameters:
- DATA_WIDTH, 32: bus/register width; must be a multiple of 8.
- ADDR_WIDTH, 16: byte address width.
- NUM_CFG, 4: number of RW config registers (1..64).
- CFG_RST, 0: NUM_CFG*DATA_WIDTH flattened reset values; CFG[i] = CFG_RST[i*DATA_WIDTH +: DATA_WIDTH].
- STRB_WIDTH, DATA_WIDTH/8: derived localparam; not overridable.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cs  in  1  access select.
- wen  in  1  1 = write, 0 = read (qualified by cs).
- addr  in  ADDR_WIDTH  byte address.
- strb  in  STRB_WIDTH  write byte enables.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  registered read data.
- rvalid  out  1  one-cycle pulse: rdata valid.
- err  out  1  one-cycle pulse: bad access.
- cfg_out  out  NUM_CFG*DATA_WIDTH  config register contents, flattened.
- cfg_wr  out  NUM_CFG  one-cycle pulse per register written.
- sts_in  in  DATA_WIDTH  live read-only hardware status.
- evt_in  in  DATA_WIDTH  event pulses; set sticky bits.
- irq  out  1  registered interrupt.

Behaviour:
- Single clock domain. On rstn low, asynchronously: CFG[i] = CFG_RST slice, EVT = 0, IEN = 0, rdata = 0, rvalid = 0, err = 0, cfg_wr = 0, irq = 0.
- Address map (byte offsets, word aligned):
  - CFG[i] at 4*i (RW).
  - STATUS at 4*NUM_CFG (RO, returns sts_in).
  - EVT at 4*NUM_CFG+4 (W1C).
  - IEN at 4*NUM_CFG+8 (RW).
- Access is bad if addr[1:0] != 0 or the offset lies beyond IEN. A bad access has no side effects: err = 1 next cycle; for a read, rvalid = 1 and rdata = 0.
- Write (cs & wen), effective at the clock edge:
  - CFG/IEN: byte k updated only where strb[k] = 1.
  - EVT: a bit is cleared where wdata = 1 within a strobed byte.
  - STATUS write: ignored, no err.
  - Writing CFG[i] with any strb bit set pulses cfg_wr[i] for exactly one cycle, the cycle after the write. With strb = 0: no update, no pulse, no err.
- Read (cs & !wen): rdata and rvalid are registered, latency 1 cycle.
  - rdata samples the register value before any same-edge update; EVT reads its pre-clear value.
  - rdata holds its value until the next read.
  - rvalid is low in every cycle without a read. Back-to-back reads give rvalid on consecutive cycles.
- EVT update per bit: EVT_next = evt_in | (EVT & ~clr).
  - A set in the same cycle as a W1C clear wins; the bit stays 1.
  - evt_in is level-sampled every cycle regardless of bus activity.
- irq is registered: irq_next = |(EVT_next & IEN_next). It asserts 1 cycle after the event edge and deasserts 1 cycle after the clear or disable edge.
- No back-pressure: one access per cycle accepted unconditionally. cs low means no action and no pulses.
- Reset asserted mid-access aborts it; no pulse is emitted after reset release.

Test Plan:
- Reset defaults. Set NUM_CFG = 2 and CFG_RST = {32'h0000_00FF, 32'h1234_5678}, then release reset. Read 0x0 and 0x4 → rdata 0x12345678 then 0x000000FF, each with rvalid 1 cycle after cs. irq = 0.
- Byte strobes. Write 0xAABBCCDD to 0x0 with strb = 4'b0101 → CFG[0] = 0x12BB56DD. cfg_wr[0] pulses for exactly 1 cycle. Write again with strb = 0 → no change, no pulse.
- W1C and IRQ. Write IEN (0x10) = 0x5, then pulse evt_in = 0x3 → EVT = 0x3 and irq = 1 one cycle later. Write EVT (0x0C) = 0x1 → EVT = 0x2, irq = 0 the next cycle.
- Set-beats-clear. evt_in = 0x4 in the same cycle as EVT W1C of 0x4 → EVT[2] stays 1, irq stays 1.
- Errors. Read 0x2 (misaligned) and 0x14 (unmapped) → err and rvalid each pulse, rdata = 0, no state change. Write to STATUS → no err, no change. sts_in = 0xCAFE read at 0x8 → 0x0000CAFE.
- Async reset. Assert rstn in the middle of a write cycle → all outputs go to 0 or defaults immediately. After release: no cfg_wr pulse, CFG back to CFG_RST.

Source files
------------

// File: rtl/csr_bank_irq.sv
// Bank of NUM_CFG RW config registers, a live status register, a sticky W1C event register and an interrupt enable register.
// Reads return 1 cycle after the access. Writes take effect at the access edge. irq, err and cfg_wr are registered.
// There is no backpressure: one access per cycle is always accepted.
//
// Ports:
//   clk, rstn          clock; asynchronous active-low reset
//   cs/wen/addr/strb/wdata  memory-style access (byte address, byte strobes)
//   rdata/rvalid       registered read data plus a one-cycle valid pulse
//   err                one-cycle pulse on a misaligned or unmapped access
//   cfg_out/cfg_wr     flattened config contents; per-register write pulse
//   sts_in             live status, read-only
//   evt_in             event pulses into the sticky register
//   irq                registered OR of (events & enables)
module csr_bank_irq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_CFG    = 4,
    parameter logic [NUM_CFG*DATA_WIDTH-1:0] CFG_RST = '0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cs,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [DATA_WIDTH/8-1:0]       strb,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          rvalid,
    output logic                          err,
    output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_out,
    output logic [NUM_CFG-1:0]            cfg_wr,
    input  logic [DATA_WIDTH-1:0]         sts_in,
    input  logic [DATA_WIDTH-1:0]         evt_in,
    output logic                          irq
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WW         = ADDR_WIDTH - 2;

    // Word indices of the registers that sit after the config array.
    localparam logic [WW-1:0] STS_IDX = WW'(NUM_CFG);
    localparam logic [WW-1:0] EVT_IDX = WW'(NUM_CFG + 1);
    localparam logic [WW-1:0] IEN_IDX = WW'(NUM_CFG + 2);

    logic [WW-1:0]         word;
    logic                  aligned;
    logic                  hit_cfg;
    logic                  hit_sts;
    logic                  hit_evt;
    logic                  hit_ien;
    logic                  bad;
    logic                  do_wr;
    logic                  do_rd;
    logic [DATA_WIDTH-1:0] bmask;
    logic [DATA_WIDTH-1:0] evt_clr;
    logic [DATA_WIDTH-1:0] evt_nxt;
    logic [DATA_WIDTH-1:0] ien_nxt;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] cfg_q [NUM_CFG];
    logic [DATA_WIDTH-1:0] evt_q;
    logic [DATA_WIDTH-1:0] ien_q;

    assign word    = addr[ADDR_WIDTH-1:2];
    assign aligned = (addr[1:0] == 2'b00);
    assign hit_cfg = aligned && (word < STS_IDX);
    assign hit_sts = aligned && (word == STS_IDX);
    assign hit_evt = aligned && (word == EVT_IDX);
    assign hit_ien = aligned && (word == IEN_IDX);

    // A bad access is decoded here once, then masked out of every side effect.
    assign bad   = cs && !(hit_cfg || hit_sts || hit_evt || hit_ien);
    assign do_wr = cs && wen && !bad;
    assign do_rd = cs && !wen;

    always_comb begin
        bmask = '0;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            bmask[8*k +: 8] = {8{strb[k]}};
        end
    end

    // Set wins over clear: evt_in is ORed in after the W1C mask is applied.
    assign evt_clr = (do_wr && hit_evt) ? (wdata & bmask) : '0;
    assign evt_nxt = evt_in | (evt_q & ~evt_clr);
    assign ien_nxt = (do_wr && hit_ien) ? ((ien_q & ~bmask) | (wdata & bmask)) : ien_q;

    // Read mux uses pre-update register values. Unmapped and misaligned reads fall through to zero.
    always_comb begin
        rd_mux = '0;
        if (hit_cfg) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (word == WW'(i)) begin
                    rd_mux = cfg_q[i];
                end
            end
        end
        if (hit_sts) rd_mux = sts_in;
        if (hit_evt) rd_mux = evt_q;
        if (hit_ien) rd_mux = ien_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= CFG_RST[i*DATA_WIDTH +: DATA_WIDTH];
            end
            cfg_wr <= '0;
            evt_q  <= '0;
            ien_q  <= '0;
            irq    <= 1'b0;
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            cfg_wr <= '0;
            for (int i = 0; i < NUM_CFG; i++) begin
                // An all-zero strobe is a no-op and must not pulse cfg_wr.
                if (do_wr && hit_cfg && (word == WW'(i)) && (|strb)) begin
                    cfg_q[i]  <= (cfg_q[i] & ~bmask) | (wdata & bmask);
                    cfg_wr[i] <= 1'b1;
                end
            end
            evt_q  <= evt_nxt;
            ien_q  <= ien_nxt;
            irq    <= |(evt_nxt & ien_nxt);
            rvalid <= do_rd;
            err    <= bad;
            if (do_rd) begin
                rdata <= rd_mux;
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
    end

endmodule

// File: tb/tb_csr_bank_irq.sv
// Bench for csr_bank_irq: directed scenarios plus randomized traffic against an in-bench reference model.
// The reference model updates on each clock edge. The checker compares all outputs on every falling edge.
// Stimulus is always accepted by the design, so there is no handshake to wait on.
module tb_csr_bank_irq;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NC = 2;
    localparam logic [NC*DW-1:0] RSTV = {32'h0000_00FF, 32'h1234_5678};

    logic           clk    = 1'b0;
    logic           rstn   = 1'b1;
    logic           cs     = 1'b0;
    logic           wen    = 1'b0;
    logic [AW-1:0]  addr   = '0;
    logic [3:0]     strb   = '0;
    logic [DW-1:0]  wdata  = '0;
    logic [DW-1:0]  sts_in = '0;
    logic [DW-1:0]  evt_in = '0;
    logic [DW-1:0]  rdata;
    logic           rvalid;
    logic           err;
    logic           irq;
    logic [NC*DW-1:0] cfg_out;
    logic [NC-1:0]  cfg_wr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Reference model state and expected registered outputs.
    logic [DW-1:0] m_cfg [NC];
    logic [DW-1:0] m_evt, m_ien, e_rdata;
    logic          e_rvalid, e_err, e_irq;
    logic [NC-1:0] e_cfgwr;

    csr_bank_irq #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CFG    (NC),
        .CFG_RST    (RSTV)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .cs      (cs),
        .wen     (wen),
        .addr    (addr),
        .strb    (strb),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .err     (err),
        .cfg_out (cfg_out),
        .cfg_wr  (cfg_wr),
        .sts_in  (sts_in),
        .evt_in  (evt_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. The register file is an array indexed by word offset. Reads see the values from before the edge.
    always @(posedge clk or negedge rstn) begin
        int            idx;
        bit            bad;
        logic [DW-1:0] mask, clr, rval;
        if (!rstn) begin
            m_cfg[0] = RSTV[31:0];
            m_cfg[1] = RSTV[63:32];
            m_evt = '0; m_ien = '0; e_rdata = '0;
            e_rvalid = 1'b0; e_err = 1'b0; e_irq = 1'b0; e_cfgwr = '0;
        end else begin
            idx = int'(addr) / 4;
            bad = cs && ((addr % 4) != 0 || idx > NC + 2);
            for (int k = 0; k < 4; k++) mask[8*k +: 8] = strb[k] ? 8'hFF : 8'h00;
            if (bad)             rval = '0;
            else if (idx < NC)   rval = m_cfg[idx];
            else if (idx == NC)  rval = sts_in;
            else if (idx == NC+1) rval = m_evt;
            else                 rval = m_ien;
            e_rvalid = cs && !wen;
            e_err    = bad;
            e_cfgwr  = '0;
            if (cs && !wen) e_rdata = rval;
            clr = '0;
            if (cs && wen && !bad) begin
                if (idx < NC && strb != 0) begin
                    m_cfg[idx]   = (m_cfg[idx] & ~mask) | (wdata & mask);
                    e_cfgwr[idx] = 1'b1;
                end else if (idx == NC + 1) begin
                    clr = wdata & mask;
                end else if (idx == NC + 2) begin
                    m_ien = (m_ien & ~mask) | (wdata & mask);
                end
            end
            m_evt = evt_in | (m_evt & ~clr);
            e_irq = |(m_evt & m_ien);
        end
    end

    // Single compare process: every output, every cycle, once the bench is out of reset.
    always @(negedge clk) begin
        if (chk_on && rstn) begin
            chk("rdata",   rdata,   e_rdata);
            chk("rvalid",  rvalid,  e_rvalid);
            chk("err",     err,     e_err);
            chk("irq",     irq,     e_irq);
            chk("cfg_wr",  cfg_wr,  e_cfgwr);
            chk("cfg_out", cfg_out, {m_cfg[1], m_cfg[0]});
        end
    end

    // Present one access for one clock, returning at the falling edge where its results are visible.
    task automatic acc(input logic w, input logic [AW-1:0] a, input logic [3:0] s, input logic [DW-1:0] d);
        cs = 1'b1; wen = w; addr = a; strb = s; wdata = d;
        @(negedge clk);
        cs = 1'b0; wen = 1'b0;
    endtask

    task automatic idle();
        cs = 1'b0; wen = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        #2;
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_err",     err,     1'b0);
        chk("rst_irq",     irq,     1'b0);
        chk("rst_cfg_wr",  cfg_wr,  2'b00);
        chk("rst_rdata",   rdata,   32'h0);
        chk("rst_cfg_out", cfg_out, RSTV);
        repeat (2) @(negedge clk);
        rstn   = 1'b1;
        chk_on = 1'b1;

        // Reset values read back.
        acc(0, 16'h0, 4'h0, '0);
        chk("rd_cfg0", rdata, 32'h1234_5678);
        chk("rd_cfg0_vld", rvalid, 1'b1);
        acc(0, 16'h4, 4'h0, '0);
        chk("rd_cfg1", rdata, 32'h0000_00FF);
        idle();
        chk("rvalid_idle", rvalid, 1'b0);
        chk("rdata_hold", rdata, 32'h0000_00FF);

        // Byte strobes.
        acc(1, 16'h0, 4'b0101, 32'hAABB_CCDD);
        chk("strb_cfg0", cfg_out[31:0], 32'h12BB_56DD);
        chk("strb_pulse", cfg_wr, 2'b01);
        idle();
        chk("strb_pulse_end", cfg_wr, 2'b00);
        acc(1, 16'h0, 4'b0000, 32'hFFFF_FFFF);
        chk("strb0_pulse", cfg_wr, 2'b00);
        chk("strb0_cfg0", cfg_out[31:0], 32'h12BB_56DD);

        // W1C and irq.
        acc(1, 16'h10, 4'hF, 32'h5);
        evt_in = 32'h3;
        idle();
        evt_in = '0;
        chk("irq_set", irq, 1'b1);
        acc(0, 16'hC, 4'h0, '0);
        chk("evt_rd", rdata, 32'h3);
        acc(1, 16'hC, 4'hF, 32'h1);
        chk("irq_clr", irq, 1'b0);
        acc(0, 16'hC, 4'h0, '0);
        chk("evt_after_clr", rdata, 32'h2);

        // Set beats clear.
        evt_in = 32'h4;
        idle();
        evt_in = '0;
        chk("irq_bit2", irq, 1'b1);
        evt_in = 32'h4;
        acc(1, 16'hC, 4'hF, 32'h4);
        evt_in = '0;
        chk("set_beats_clr_irq", irq, 1'b1);
        acc(0, 16'hC, 4'h0, '0);
        chk("set_beats_clr_evt", rdata, 32'h6);

        // Bad accesses and status.
        acc(0, 16'h2, 4'h0, '0);
        chk("misal_err", err, 1'b1);
        chk("misal_vld", rvalid, 1'b1);
        chk("misal_rdata", rdata, 32'h0);
        acc(0, 16'h14, 4'h0, '0);
        chk("unmap_err", err, 1'b1);
        chk("unmap_rdata", rdata, 32'h0);
        acc(1, 16'h14, 4'hF, 32'hFFFF_FFFF);
        chk("unmap_wr_err", err, 1'b1);
        chk("unmap_wr_cfg", cfg_out, {32'h0000_00FF, 32'h12BB_56DD});
        acc(1, 16'h8, 4'hF, 32'hFFFF_FFFF);
        chk("sts_wr_err", err, 1'b0);
        sts_in = 32'h0000_CAFE;
        acc(0, 16'h8, 4'h0, '0);
        chk("sts_rd", rdata, 32'h0000_CAFE);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            cs   = ($urandom_range(0, 3) != 0);
            wen  = 1'($urandom_range(0, 1));
            addr = 16'($urandom_range(0, 23));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            strb   = 4'($urandom);
            wdata  = $urandom;
            sts_in = $urandom;
            evt_in = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            @(negedge clk);
        end
        evt_in = '0;
        idle();

        // Async reset in the middle of a write.
        cs = 1'b1; wen = 1'b1; addr = 16'h4; strb = 4'hF; wdata = 32'hDEAD_BEEF;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_cfg", cfg_out, RSTV);
        chk("mid_rst_irq", irq, 1'b0);
        chk("mid_rst_cfg_wr", cfg_wr, 2'b00);
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        repeat (2) @(negedge clk);
        cs = 1'b0; wen = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_cfg_wr", cfg_wr, 2'b00);
        chk("post_rst_cfg", cfg_out, RSTV);
        acc(0, 16'h4, 4'h0, '0);
        chk("post_rst_rd", rdata, 32'h0000_00FF);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
